// File: rtl/seq_div16.sv
// seq_div16: sequential restoring unsigned divider.
// Resolves one quotient bit per clock through a WIDTH+1-bit trial subtraction
// whose MSB is the borrow. Uses a start/busy/done handshake, returns quotient,
// remainder and a divide-by-zero flag. All outputs come straight from flops.
module seq_div16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Datapath for one iteration. The partial remainder before any step holds
  // only the already-consumed dividend prefix (fewer than WIDTH bits), so
  // dropping its MSB on the shift never loses information.
  logic [WIDTH-1:0] rem_sh_s;
  logic [WIDTH:0]   trial_s;
  logic             no_borrow_s;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;

  // One restoring step: shift, trial subtract, pick remainder, new quotient bit.
  always_comb begin
    rem_sh_s    = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    trial_s     = {1'b0, rem_sh_s} - {1'b0, dvsr_q};
    no_borrow_s = ~trial_s[WIDTH];
    if (no_borrow_s) begin
      rem_nx_s = trial_s[WIDTH-1:0];
    end else begin
      rem_nx_s = rem_sh_s;
    end
    quo_nx_s = {quo_q[WIDTH-2:0], no_borrow_s};
  end

  // Next-state and next-output logic; every register holds unless told otherwise.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (divisor == {WIDTH{1'b0}}) begin
            // Divide-by-zero resolves immediately, no iterations.
            state_d     = S_DONE;
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            rem_d   = {WIDTH{1'b0}};
            quo_d   = dividend;
            dvsr_d  = divisor;
            cnt_d   = CW'(WIDTH);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        rem_d = rem_nx_s;
        quo_d = quo_nx_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_DONE;
          quotient_d  = quo_nx_s;
          remainder_d = rem_nx_s;
          div_zero_d  = 1'b0;
        end else begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= {WIDTH{1'b0}};
      quo_q       <= {WIDTH{1'b0}};
      dvsr_q      <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      div_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div16.sv
// Self-checking bench for seq_div16: directed corner cases plus randomized
// divisions compared against a plain-arithmetic reference (/ and %).
module tb_seq_div16;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_zero;

  int n_vec = 0;
  int n_err = 0;

  // Expected visible results (held until the next completion).
  logic [W-1:0] exp_q  = 16'h0000;
  logic [W-1:0] exp_r  = 16'h0000;
  logic         exp_dz = 1'b0;

  seq_div16 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain arithmetic, with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 16'h0000) begin
      exp_q  = 16'hFFFF;
      exp_r  = a;
      exp_dz = 1'b1;
    end else begin
      exp_q  = a / b;
      exp_r  = a % b;
      exp_dz = 1'b0;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic busy_e, input logic done_e);
    chk({tag, ".busy"}, 32'(busy), 32'(busy_e));
    chk({tag, ".done"}, 32'(done), 32'(done_e));
    chk({tag, ".quotient"}, 32'(quotient), 32'(exp_q));
    chk({tag, ".remainder"}, 32'(remainder), 32'(exp_r));
    chk({tag, ".div_zero"}, 32'(div_zero), 32'(exp_dz));
  endtask

  // Launch one division (in IDLE or DONE) and follow it to its done cycle.
  // inject_at >= 0 pulses start with junk operands at that RUN cycle index.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    if (b != 16'h0000) begin
      for (int k = 0; k < W; k++) begin
        check_outputs("run", 1'b1, 1'b0);
        if (k == inject_at) begin
          start    = 1'b1;
          dividend = 16'($urandom);
          divisor  = 16'($urandom);
        end
        tick;
        start = 1'b0;
      end
    end
    model(a, b);
    check_outputs("done", 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      tick;
      check_outputs("idle", 1'b0, 1'b0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 16'h0000;
    divisor  = 16'h0000;
    repeat (3) tick;
    check_outputs("reset", 1'b0, 1'b0);
    reset = 1'b0;
    idle(2);

    // Nominal and extremes.
    run_div(16'd100, 16'd7, -1);
    idle(1);
    run_div(16'hFFFF, 16'h0001, -1);
    idle(1);
    run_div(16'hFFFF, 16'hFFFF, -1);
    idle(1);
    run_div(16'd5, 16'd9, -1);
    idle(2);

    // Divide-by-zero: one-cycle latency, busy never set.
    run_div(16'h1234, 16'h0000, -1);
    idle(2);

    // start during RUN is ignored.
    run_div(16'd100, 16'd7, 4);
    idle(1);

    // Back-to-back: next start accepted in the DONE cycle.
    run_div(16'd100, 16'd7, -1);
    run_div(16'd1000, 16'd3, -1);
    run_div(16'hABCD, 16'h0000, -1);
    run_div(16'd77, 16'd7, -1);
    idle(1);

    // Reset at RUN cycle 8 aborts cleanly.
    start    = 1'b1;
    dividend = 16'd100;
    divisor  = 16'd7;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check_outputs("prerst", 1'b1, 1'b0);
      tick;
    end
    reset = 1'b1;
    tick;
    reset  = 1'b0;
    exp_q  = 16'h0000;
    exp_r  = 16'h0000;
    exp_dz = 1'b0;
    check_outputs("abort", 1'b0, 1'b0);
    idle(20);
    run_div(16'd100, 16'd7, -1);
    idle(1);

    // Randomized divisions.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           sel;
      int           inj;
      sel = int'($urandom_range(0, 5));
      a   = 16'($urandom);
      if (sel == 0)      b = 16'h0000;
      else if (sel == 1) b = 16'h0001;
      else if (sel == 2) b = 16'($urandom_range(1, 15));
      else if (sel == 3) b = 16'($urandom_range(16'h8000, 16'hFFFF));
      else               b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 31));
      inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      run_div(a, b, inj);
      idle(int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
